// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for dmem_arbiter: FSM states, port count,
// RISC-V load/store funct3 codes and the latched request record.
package dmem_arb_pkg;

    localparam int NUM_PORTS   = 2;
    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_arb_state_e;

    // Sized for the default memory geometry; the top level uses the same widths.
    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [2:0]             funct3;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of dmem_arbiter: two request ports, grant and response.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic [1:0]            req_i;
    logic [1:0]            we_i;
    logic [DM_ADDRESS-1:0] addr0_i;
    logic [DM_ADDRESS-1:0] addr1_i;
    logic [DATA_W-1:0]     wdata0_i;
    logic [DATA_W-1:0]     wdata1_i;
    logic [2:0]            funct3_0_i;
    logic [2:0]            funct3_1_i;
    logic [1:0]            gnt_o;
    logic [1:0]            rvalid_o;
    logic [DATA_W-1:0]     rdata_o;

    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
               funct3_0_i, funct3_1_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i,
               funct3_0_i, funct3_1_i,
        output gnt_o, rvalid_o, rdata_o
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input grant logic. Round-robin on a 1-bit last-winner pointer by default;
// DMEM_ARB_FIXED_PRIO_EN reduces it to a port-0-first priority encoder.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic last_q;
`endif

    always_comb begin
        // NOTE: assigning every output a default first keeps this block free of latches.
        gnt = '0;
        if (en) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
`else
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
`endif
        end
    end

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = clk ^ reset;
`else
    // Pointer starts at 1 so that port 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only.
        if (reset) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single datamemory port between two requesters; one grant at a time.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DM_ADDRESS = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arbiter_if.slave         bus,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    output logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     rd
);

    dmem_arb_state_e   state_q, state_d;
    dmem_req_t         req_q, req_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic [1:0]        gnt;

    // Grants are only issued while the memory port is free for the next cycle.
    assign accept = (state_q == IDLE) || (state_q == RESP);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .req   (bus.req_i),
        .gnt   (gnt)
    );

    assign bus.gnt_o   = gnt;
    assign bus.rdata_o = rdata_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt[0]) begin
                    state_d = ACCESS;
                    id_d    = 1'b0;
                    req_d   = '{we: bus.we_i[0], addr: bus.addr0_i,
                                wdata: bus.wdata0_i, funct3: bus.funct3_0_i};
                end else if (gnt[1]) begin
                    state_d = ACCESS;
                    id_d    = 1'b1;
                    req_d   = '{we: bus.we_i[1], addr: bus.addr1_i,
                                wdata: bus.wdata1_i, funct3: bus.funct3_1_i};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            id_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            // The memory read on ~clk has settled by the edge that ends ACCESS.
            if (state_q == ACCESS && !req_q.we) begin
                rdata_q <= rd;
            end
        end
    end

    // Memory-side outputs decode from state and the request latch only, so the
    // memory never sees a stale enable and no input reaches them combinationally.
    always_comb begin
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        a            = '0;
        wd           = '0;
        Funct3       = '0;
        bus.rvalid_o = '0;
        if (state_q == ACCESS) begin
            MemRead  = !req_q.we;
            MemWrite = req_q.we;
            a        = req_q.addr;
            wd       = req_q.wdata;
            Funct3   = req_q.funct3;
        end
        if (state_q == RESP) begin
            bus.rvalid_o[id_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian byte memory model that
// stands in for datamemory (clocked on the falling edge).
`timescale 1ns/1ps
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  a;
    logic [31:0] wd;
    logic [2:0]  Funct3;
    logic [31:0] rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:511];
    int mw_cnt  = 0;
    int g1_cnt  = 0;
    int rv1_cnt = 0;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .a        (a),
        .wd       (wd),
        .Funct3   (Funct3),
        .rd       (rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bidx(input logic [8:0] adr, input int k);
        return (int'(adr) + k) % 512;
    endfunction

    function automatic logic [31:0] mem_load(input logic [8:0] adr, input logic [2:0] f3);
        logic [31:0] w;
        w = {mem[bidx(adr, 3)], mem[bidx(adr, 2)], mem[bidx(adr, 1)], mem[bidx(adr, 0)]};
        case (f3)
            F3_LB:   return {{24{w[7]}}, w[7:0]};
            F3_LH:   return {{16{w[15]}}, w[15:0]};
            F3_LW:   return w;
            F3_LBU:  return {24'h0, w[7:0]};
            F3_LHU:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    // Memory model plus activity counters, all on the falling edge.
    always @(negedge clk) begin
        if (MemWrite) begin
            mw_cnt <= mw_cnt + 1;
            case (Funct3)
                F3_SB: mem[bidx(a, 0)] <= wd[7:0];
                F3_SH: begin
                    mem[bidx(a, 0)] <= wd[7:0];
                    mem[bidx(a, 1)] <= wd[15:8];
                end
                F3_SW: begin
                    mem[bidx(a, 0)] <= wd[7:0];
                    mem[bidx(a, 1)] <= wd[15:8];
                    mem[bidx(a, 2)] <= wd[23:16];
                    mem[bidx(a, 3)] <= wd[31:24];
                end
                default: ;
            endcase
        end
        if (MemRead) rd <= mem_load(a, Funct3);
        if (bus.gnt_o[1]) g1_cnt <= g1_cnt + 1;
        if (bus.rvalid_o[1]) rv1_cnt <= rv1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic we, input logic [8:0] adr,
                            input logic [31:0] wdat, input logic [2:0] f3);
        if (p == 0) begin
            bus.we_i[0]    = we;
            bus.addr0_i    = adr;
            bus.wdata0_i   = wdat;
            bus.funct3_0_i = f3;
        end else begin
            bus.we_i[1]    = we;
            bus.addr1_i    = adr;
            bus.wdata1_i   = wdat;
            bus.funct3_1_i = f3;
        end
    endtask

    initial begin
        logic [8:0]  b2b_addr [3];
        logic [31:0] b2b_data [3];
        int ptr, win, prev, mw0, g10, rv10;

        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]} = 32'h11223344;
        {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]} = 32'hDEADBEEF;
        {mem[16'h33], mem[16'h32], mem[16'h31], mem[16'h30]} = 32'hCAFEF00D;
        rd = '0;
        reset = 1'b1;
        bus.req_i = '0;
        set_port(0, 1'b0, 9'h0, 32'h0, 3'b000);
        set_port(1, 1'b0, 9'h0, 32'h0, 3'b000);

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_gnt",    32'(bus.gnt_o),    32'h0);
        check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("rst_rdata",  bus.rdata_o,       32'h0);
        check("rst_memrd",  32'(MemRead),      32'h0);
        check("rst_memwr",  32'(MemWrite),     32'h0);
        check("rst_a",      32'(a),            32'h0);

        // Single load, port 0
        set_port(0, 1'b0, 9'h010, 32'h0, F3_LW);
        bus.req_i = 2'b01;
        #1 check("ld0_gnt", 32'(bus.gnt_o), 32'h1);
        step();
        check("ld0_memrd",  32'(MemRead),  32'h1);
        check("ld0_memwr",  32'(MemWrite), 32'h0);
        check("ld0_a",      32'(a),        32'h010);
        check("ld0_funct3", 32'(Funct3),   32'h2);
        check("ld0_gnt_acc", 32'(bus.gnt_o), 32'h0);
        bus.req_i = 2'b00;
        step();
        check("ld0_rvalid", 32'(bus.rvalid_o), 32'h1);
        check("ld0_rdata",  bus.rdata_o,       32'h11223344);
        check("ld0_memrd_resp", 32'(MemRead),  32'h0);
        step();

        // SB then LBU, port 1
        mw0 = mw_cnt;
        set_port(1, 1'b1, 9'h013, 32'h000000A5, F3_SB);
        bus.req_i = 2'b10;
        #1 check("sb_gnt", 32'(bus.gnt_o), 32'h2);
        step();
        check("sb_memwr", 32'(MemWrite), 32'h1);
        check("sb_memrd", 32'(MemRead),  32'h0);
        check("sb_a",     32'(a),        32'h013);
        check("sb_wd",    wd,            32'h000000A5);
        check("sb_funct3", 32'(Funct3),  32'h0);
        bus.req_i = 2'b00;
        step();
        check("sb_rvalid", 32'(bus.rvalid_o), 32'h2);
        check("sb_memwr_off", 32'(MemWrite), 32'h0);
        check("sb_rdata_kept", bus.rdata_o, 32'h11223344);
        set_port(1, 1'b0, 9'h013, 32'h0, F3_LBU);
        bus.req_i = 2'b10;
        #1 check("lbu_gnt_in_resp", 32'(bus.gnt_o), 32'h2);
        step();
        bus.req_i = 2'b00;
        step();
        check("lbu_rvalid", 32'(bus.rvalid_o), 32'h2);
        check("lbu_rdata",  bus.rdata_o,       32'h000000A5);
        check("sb_memwr_cycles", 32'(mw_cnt - mw0), 32'h1);
        step();

        // Simultaneous requests held continuously
        ptr  = 1;
        prev = 0;
        set_port(0, 1'b0, 9'h020, 32'h0, F3_LW);
        set_port(1, 1'b0, 9'h030, 32'h0, F3_LW);
        bus.req_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            win = 0;
`else
            win = (ptr == 1) ? 0 : 1;
`endif
            ptr = win;
            check("tie_gnt", 32'(bus.gnt_o), (win == 1) ? 32'h2 : 32'h1);
            if (k > 0) begin
                check("tie_rvalid", 32'(bus.rvalid_o), (prev == 1) ? 32'h2 : 32'h1);
                check("tie_rdata", bus.rdata_o, (prev == 1) ? 32'hCAFEF00D : 32'hDEADBEEF);
            end
            step();
            check("tie_gnt_acc", 32'(bus.gnt_o), 32'h0);
            check("tie_a", 32'(a), (win == 1) ? 32'h030 : 32'h020);
            if (k == 3) bus.req_i = 2'b00;
            step();
            prev = win;
        end
        check("tie_last_rvalid", 32'(bus.rvalid_o), (prev == 1) ? 32'h2 : 32'h1);
        check("tie_last_rdata", bus.rdata_o, (prev == 1) ? 32'hCAFEF00D : 32'hDEADBEEF);
        check("tie_idle_gnt", 32'(bus.gnt_o), 32'h0);
        step();

        // Back-to-back loads from port 0
        b2b_addr[0] = 9'h010; b2b_data[0] = 32'hA5223344;
        b2b_addr[1] = 9'h020; b2b_data[1] = 32'hDEADBEEF;
        b2b_addr[2] = 9'h030; b2b_data[2] = 32'hCAFEF00D;
        set_port(0, 1'b0, b2b_addr[0], 32'h0, F3_LW);
        bus.req_i = 2'b01;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("b2b_gnt", 32'(bus.gnt_o), 32'h1);
            if (k > 0) begin
                check("b2b_rvalid", 32'(bus.rvalid_o), 32'h1);
                check("b2b_rdata", bus.rdata_o, b2b_data[k-1]);
            end
            step();
            check("b2b_a", 32'(a), 32'(b2b_addr[k]));
            if (k < 2) bus.addr0_i = b2b_addr[k+1];
            else bus.req_i = 2'b00;
            step();
        end
        check("b2b_last_rvalid", 32'(bus.rvalid_o), 32'h1);
        check("b2b_last_rdata", bus.rdata_o, b2b_data[2]);
        step();

        // Reset during ACCESS of a load
        set_port(0, 1'b0, 9'h020, 32'h0, F3_LW);
        bus.req_i = 2'b01;
        step();
        check("rstacc_memrd_before", 32'(MemRead), 32'h1);
        reset = 1'b1;
        bus.req_i = 2'b00;
        step();
        check("rstacc_memrd", 32'(MemRead), 32'h0);
        check("rstacc_rvalid", 32'(bus.rvalid_o), 32'h0);
        check("rstacc_rdata", bus.rdata_o, 32'h0);
        reset = 1'b0;
        step();
        check("rstacc_no_resp", 32'(bus.rvalid_o), 32'h0);
        set_port(0, 1'b0, 9'h010, 32'h0, F3_LW);
        set_port(1, 1'b0, 9'h020, 32'h0, F3_LW);
        bus.req_i = 2'b11;
        #1 check("rstacc_tie_gnt", 32'(bus.gnt_o), 32'h1);
        step();
        bus.req_i = 2'b00;
        step();
        check("rstacc_rvalid2", 32'(bus.rvalid_o), 32'h1);
        check("rstacc_rdata2", bus.rdata_o, 32'hA5223344);
        step();

        // Request withdrawal by port 1 while port 0 owns the memory
        g10  = g1_cnt;
        rv10 = rv1_cnt;
        set_port(0, 1'b0, 9'h030, 32'h0, F3_LW);
        bus.req_i = 2'b01;
        #1 check("wd_gnt", 32'(bus.gnt_o), 32'h1);
        step();
        bus.req_i = 2'b11;
        #1 check("wd_gnt_acc", 32'(bus.gnt_o), 32'h0);
        step();
        bus.req_i = 2'b00;
        #1 check("wd_rvalid", 32'(bus.rvalid_o), 32'h1);
        check("wd_gnt_resp", 32'(bus.gnt_o), 32'h0);
        step();
        step();
        check("wd_p1_gnts", 32'(g1_cnt - g10), 32'h0);
        check("wd_p1_rvalids", 32'(rv1_cnt - rv10), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer in front of the `datamemory` block. It shares the single data memory port between the pipeline load/store stage (port 0) and a secondary requester such as a debug or program loader (port 1). It registers one granted transaction, drives `MemRead`/`MemWrite`/`a`/`wd`/`Funct3` for exactly one cycle, and returns read data or a write acknowledge to the winning port.

## Interface
- `DM_ADDRESS`, default 9: memory address width.
- `DATA_W`, default 32: data width.
- `clk` input 1: clock. The memory is clocked on `~clk` internally; the arbiter uses rising `clk` only.
- `reset` input 1: synchronous, active-high reset.
- `req_i[1:0]` input 2: per-port request.
- `we_i[1:0]` input 2: per-port write enable (1 = store, 0 = load).
- `addr0_i`, `addr1_i` input DM_ADDRESS: per-port byte address.
- `wdata0_i`, `wdata1_i` input DATA_W: per-port store data.
- `funct3_0_i`, `funct3_1_i` input 3: per-port access size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `gnt_o[1:0]` output 2: combinational grant, one-hot or zero.
- `rvalid_o[1:0]` output 2: one-cycle response pulse for the granted port, for both loads and stores.
- `rdata_o` output DATA_W: registered load data. It is valid only while an `rvalid_o` bit is set for a load.
- `MemRead`, `MemWrite` output 1: to datamemory.
- `a` output DM_ADDRESS, `wd` output DATA_W, `Funct3` output 3: to datamemory.
- `rd` input DATA_W: from datamemory.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE / RESP (accepting states)**
  - If any `req_i` bit is set, assert the single winner's `gnt_o` bit.
  - At the rising edge, latch that port's we/addr/wdata/funct3 and port id, then go to ACCESS.
  - With no request: IDLE stays IDLE, and RESP goes to IDLE.
- **ACCESS** (exactly one cycle)
  - Drive `a`, `wd` and `Funct3` from the latched fields.
  - `MemRead` = !we and `MemWrite` = we.
  - `gnt_o` = 0.
  - At the edge, capture `rd` into `rdata_o` (loads only; stores leave `rdata_o` unchanged), then go to RESP.
- **RESP**
  - `rvalid_o[id]` = 1 for one cycle.
  - A new grant may be issued in the same cycle, as described under the accepting states.
- **Arbitration**
  - Round-robin with a 1-bit last-winner pointer. On a simultaneous request, the port that did not win last is granted.
  - The pointer updates only on a grant. Reset value is 1, so port 0 wins the first tie.
- Outside ACCESS, `MemRead`, `MemWrite`, `a`, `wd` and `Funct3` are all 0. The memory never sees a stale enable.
- **Requester rules**
  - Hold req and fields stable until `gnt_o` is sampled high.
  - Dropping req before a grant is legal and has no effect.
  - The arbiter does not check alignment. Address and funct3 pass through unmodified; datamemory handles byte lanes.
- **Reset**
  - All registers clear at the next rising edge: state IDLE, pointer 1, `rdata_o` 0, `rvalid_o` 0.
  - An in-flight ACCESS or RESP is abandoned and no `rvalid_o` is produced for it. A store in ACCESS during the reset edge may or may not complete.

## Timing
- Grant in cycle N; memory access in N+1; `rvalid_o` and `rdata_o` in N+2.
- Back-to-back throughput is one transaction per 2 cycles: the next grant is issued in RESP, so the next ACCESS falls at N+3.
- `gnt_o` is combinational from state, `req_i` and the pointer. All other outputs come from registers or decode state only; there is no combinational input-to-output path except to `gnt_o`.
- Load data is captured at the rising edge ending ACCESS. The memory read on `~clk` falls mid-cycle and settles before that edge.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority. Port 0 always wins a tie and the round-robin pointer is not built.
- Undefined (default): round-robin as described above.

## Structure
- Package `dmem_arb_pkg` holds:
  - State enum `dmem_arb_state_e` (IDLE, ACCESS, RESP).
  - `NUM_PORTS = 2`.
  - Funct3 localparams for LB/LH/LW/LBU/LHU and SB/SH/SW, shared with datamemory users.
  - Struct `dmem_req_t` {we, addr, wdata, funct3}.
- One sub-module, `rr_arb2`: 2-input grant logic plus last-winner pointer. Under the macro it reduces to a fixed-priority encoder.
- The top level holds the FSM, the request latch and the response register.

## Test plan
- **Single load, port 0.** Preload word 0x11223344 at addr 0x010; `req_i`=01, we=0, addr 0x010, funct3 010.
  - `gnt_o`=01 in N.
  - `MemRead`=1, `a`=0x010 in N+1.
  - `rvalid_o`=01, `rdata_o`=0x11223344 in N+2.
- **SB then LBU, port 1.** SB 0xA5 to 0x013, then LBU 0x013.
  - `rvalid_o`=10 for the store.
  - Load returns 0x000000A5; `MemWrite` is high for exactly one cycle.
- **Simultaneous requests.** `req_i`=11 held continuously.
  - Grants go 01, 10, 01, 10 on cycles N, N+2, N+4, N+6.
  - With `DMEM_ARB_FIXED_PRIO_EN` defined, every grant is 01.
- **Back-to-back.** Port 0 issues 3 loads with req held.
  - Grants come every 2 cycles.
  - Each `rvalid_o` coincides with the next `gnt_o`, and the returned data matches each address.
- **Reset in ACCESS.** Assert `reset` for 1 cycle during ACCESS of a load.
  - No `rvalid_o`; state IDLE; `MemRead`=0 after the edge.
  - The next `req_i`=11 grants port 0.
- **Request withdrawal.** Port 1 raises req for 1 cycle while port 0 has the grant, then drops it.
  - Port 1 never receives `gnt_o` or `rvalid_o`.
